// File: rtl/python_transmitter_10bit.sv
`default_nettype none
//==============================================================================
// Module   : python_transmitter_10bit
// Brief    : PYTHON sensor link word generator (training, sync codes, test
//            pattern pixels) for the parallel side of per-lane 10:1 serialisers.
// Options  : define PYTHON_TX_CHECKSUM_EN to append a per-line checksum word.
// Revision : 1.0 - initial release
//==============================================================================
module python_transmitter_10bit #(
    parameter int         CHANNELS  = 4,
    parameter int         H_KERNELS = 64,
    parameter int         V_LINES   = 480,
    parameter int         H_BLANK   = 16,
    parameter int         V_BLANK   = 8,
    parameter logic [9:0] CODE_TR   = 10'h3A6,
    parameter logic [9:0] CODE_FS   = 10'h2AA,
    parameter logic [9:0] CODE_FE   = 10'h3AA,
    parameter logic [9:0] CODE_LS   = 10'h0AA,
    parameter logic [9:0] CODE_LE   = 10'h12A,
    parameter logic [9:0] CODE_IMG  = 10'h035,
    parameter logic [9:0] CODE_CRC  = 10'h059
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     cke,
    input  logic                     enable,
    input  logic [1:0]               pattern_sel,
    output logic [CHANNELS-1:0][9:0] out_data,
    output logic [9:0]               out_sync,
    output logic                     out_frame_start,
    output logic                     out_busy
);

`ifdef PYTHON_TX_CHECKSUM_EN
    localparam int c_LINE_PERIOD = H_KERNELS + H_BLANK + 1;
`else
    localparam int c_LINE_PERIOD = H_KERNELS + H_BLANK;
`endif
    localparam int c_VB_CYCLES = V_BLANK * c_LINE_PERIOD;
    localparam int c_CNT_MAX   = (H_BLANK > c_VB_CYCLES) ? H_BLANK : c_VB_CYCLES;
    localparam int c_XW        = $clog2(H_KERNELS);
    localparam int c_YW        = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int c_CW        = $clog2(c_CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_CRC    = 3'd2,
        S_HBLANK = 3'd3,
        S_VBLANK = 3'd4
    } state_t;

    state_t            r_state, w_state_nx;
    logic [c_XW-1:0]   r_x, w_x_nx;
    logic [c_YW-1:0]   r_y, w_y_nx;
    logic [c_CW-1:0]   r_cnt, w_cnt_nx;
    logic [15:0]       r_fcnt, w_fcnt_nx;
    logic [1:0]        r_pat, w_pat_nx;
    logic              w_frame_done;

    logic [CHANNELS-1:0][9:0] w_pix;
    logic [CHANNELS-1:0][9:0] w_data;
    logic [9:0]               w_sync;
    logic                     w_fs;
    logic                     w_busy;

    // Test-pattern pixel for each lane at the current (x, y).
    for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_lane
        assign w_pix[gc] = (r_pat == 2'd0) ? 10'(32'(r_x) * 32'(CHANNELS) + 32'(gc)) :
                           (r_pat == 2'd1) ? 10'(r_y) :
                           (r_pat == 2'd2) ? r_fcnt[9:0] :
                           ((r_x[0] ^ r_y[0]) ? 10'h3FF : 10'h000);
    end

`ifdef PYTHON_TX_CHECKSUM_EN
    logic [CHANNELS-1:0][9:0] r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (cke && (r_state == S_ACTIVE)) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c] <= ((r_x == '0) ? 10'd0 : r_acc[c]) + w_pix[c];
            end
        end
    end
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_x_nx       = r_x;
        w_y_nx       = r_y;
        w_cnt_nx     = r_cnt;
        w_fcnt_nx    = r_fcnt;
        w_pat_nx     = r_pat;
        w_frame_done = 1'b0;
        w_sync       = CODE_TR;
        w_data       = {CHANNELS{CODE_TR}};
        w_fs         = 1'b0;
        w_busy       = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nx = S_ACTIVE;
                    w_x_nx     = '0;
                    w_y_nx     = '0;
                    w_pat_nx   = pattern_sel;
                end
            end
            S_ACTIVE: begin
                w_data = w_pix;
                w_fs   = (r_x == '0) && (r_y == '0);
                if (r_x == '0)
                    w_sync = (r_y == '0) ? CODE_FS : CODE_LS;
                else if (r_x == c_XW'(H_KERNELS - 1))
                    w_sync = (r_y == c_YW'(V_LINES - 1)) ? CODE_FE : CODE_LE;
                else
                    w_sync = CODE_IMG;

                if (r_x == c_XW'(H_KERNELS - 1)) begin
                    w_x_nx   = '0;
                    w_cnt_nx = '0;
`ifdef PYTHON_TX_CHECKSUM_EN
                    w_state_nx = S_CRC;
`else
                    w_state_nx = S_HBLANK;
`endif
                end else begin
                    w_x_nx = r_x + 1'b1;
                end
            end
`ifdef PYTHON_TX_CHECKSUM_EN
            S_CRC: begin
                w_sync     = CODE_CRC;
                w_data     = r_acc;
                w_cnt_nx   = '0;
                w_state_nx = S_HBLANK;
            end
`endif
            S_HBLANK: begin
                if (r_cnt == c_CW'(H_BLANK - 1)) begin
                    w_cnt_nx = '0;
                    if (r_y == c_YW'(V_LINES - 1)) begin
                        if (c_VB_CYCLES == 0)
                            w_frame_done = 1'b1;
                        else
                            w_state_nx = S_VBLANK;
                    end else begin
                        w_y_nx     = r_y + 1'b1;
                        w_state_nx = S_ACTIVE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_VBLANK: begin
                if (r_cnt == c_CW'(c_VB_CYCLES - 1))
                    w_frame_done = 1'b1;
                else
                    w_cnt_nx = r_cnt + 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // End of vertical blank: restart back-to-back or fall back to idle.
        if (w_frame_done) begin
            w_cnt_nx = '0;
            if (enable) begin
                w_state_nx = S_ACTIVE;
                w_x_nx     = '0;
                w_y_nx     = '0;
                w_pat_nx   = pattern_sel;
                w_fcnt_nx  = r_fcnt + 16'd1;
            end else begin
                w_state_nx = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_cnt           <= '0;
            r_fcnt          <= '0;
            r_pat           <= '0;
            out_data        <= {CHANNELS{CODE_TR}};
            out_sync        <= CODE_TR;
            out_frame_start <= 1'b0;
            out_busy        <= 1'b0;
        end else if (cke) begin
            r_state         <= w_state_nx;
            r_x             <= w_x_nx;
            r_y             <= w_y_nx;
            r_cnt           <= w_cnt_nx;
            r_fcnt          <= w_fcnt_nx;
            r_pat           <= w_pat_nx;
            out_data        <= w_data;
            out_sync        <= w_sync;
            out_frame_start <= w_fs;
            out_busy        <= w_busy;
        end
    end

endmodule
`default_nettype wire

// File: doc/python_transmitter_10bit.md
# python_transmitter_10bit

Parallel-domain PYTHON sensor-side link generator. It produces the 10-bit words that a PYTHON image sensor drives on its data lanes and its sync lane: training words, frame and line sync codes, and test-pattern pixels. It sits in front of per-lane 10:1 OSERDES stages (outside this block) and drives the LVDS receive path in loopback and hardware-in-the-loop tests. It is also the stimulus source for receiver, bitslip and alignment simulations.

## Interface
Parameters:
- CHANNELS, 4, number of data lanes.
- H_KERNELS, 64, active words per lane per line; must be ≥ 3.
- V_LINES, 480, active lines per frame; must be ≥ 1.
- H_BLANK, 16, training cycles after each line; must be ≥ 1.
- V_BLANK, 8, blank line periods after each frame.
- CODE_TR, 10'h3A6, training word.
- CODE_FS / CODE_FE / CODE_LS / CODE_LE / CODE_IMG / CODE_CRC, 10'h2AA / 10'h3AA / 10'h0AA / 10'h12A / 10'h035 / 10'h059, sync-lane codes.

Ports (one clock; reset is asynchronous and active-high):
- reset, in, 1, asynchronous active-high reset.
- clk, in, 1, word clock (parallel / CLKDIV domain).
- cke, in, 1, clock enable. When low, all state and outputs hold.
- enable, in, 1, run request.
- pattern_sel, in, 2, test-pattern select. Sampled only at frame start.
- out_data, out, [CHANNELS][10], data-lane words.
- out_sync, out, 10, sync-lane word.
- out_frame_start, out, 1, one-cycle pulse aligned with the FS word.
- out_busy, out, 1, high while a frame or its vertical blank is in progress.

## Operation
States:
- IDLE:
  - All lanes emit CODE_TR.
  - When enable=1, go to ACTIVE with x=0, y=0. Latch pattern_sel. Assert out_frame_start.
- ACTIVE (x = 0..H_KERNELS-1):
  - Sync lane at x=0: CODE_FS if y==0, else CODE_LS.
  - Sync lane at x=H_KERNELS-1: CODE_FE if y==V_LINES-1, else CODE_LE.
  - Sync lane otherwise: CODE_IMG.
- CRC (only when the checksum macro is defined): one cycle, described under Configuration. Then go to HBLANK.
- HBLANK:
  - H_BLANK cycles of CODE_TR on all lanes.
  - Then: next line if y < V_LINES-1; otherwise VBLANK.
- VBLANK:
  - V_BLANK × line-period cycles of CODE_TR. Line period = H_KERNELS + H_BLANK (+1 with the checksum macro).
  - Then: if enable=1, start a new frame (y=0, latch pattern_sel, pulse out_frame_start, frame_cnt+1). Otherwise go to IDLE.
- enable is examined only in IDLE and at the end of VBLANK. Dropping enable mid-frame still completes the frame and its VBLANK.

Pixel value for lane c, all arithmetic mod 1024:
- 0: horizontal ramp, x·CHANNELS + c.
- 1: vertical ramp, y.
- 2: frame_cnt[9:0]. frame_cnt is 16-bit, wraps, reset 0.
- 3: checker, 10'h3FF if (x^y)&1, else 10'h000.

out_busy is 0 only in IDLE.

## Timing
- All outputs are registered. A state/counter value present on cycle n appears on the outputs at edge n+1.
- Reset (asynchronous, immediate):
  - out_data and out_sync = CODE_TR.
  - out_frame_start = 0, out_busy = 0.
  - State IDLE; x, y and frame_cnt = 0.
- Reset asserted mid-line abandons the frame. There is no partial FE.
- First FS appears 1 cycle after enable is sampled high in IDLE.
- cke=0 freezes everything, including out_frame_start. A pulse held under cke=0 stays high until the next cke=1 edge.
- Frame period = (V_LINES + V_BLANK) × line period, from FS to the next FS when back-to-back.

## Configuration
- PYTHON_TX_CHECKSUM_EN defined:
  - After the last ACTIVE word of each line, one CRC cycle is inserted.
  - out_sync = CODE_CRC.
  - out_data[c] = 10-bit sum, mod 1024, of all H_KERNELS words lane c sent on that line.
  - The sum accumulator clears at x=0.
  - Line period grows by 1.
- Undefined: no CRC state and no accumulators. HBLANK directly follows the last ACTIVE word.

## Test plan
- Reset: assert reset mid-ACTIVE, between edges. out_sync=10'h3A6 and all lanes 10'h3A6 immediately; out_busy=0. After release, with enable=0, it stays training.
- Frame shape: H_KERNELS=4, V_LINES=2, H_BLANK=2, V_BLANK=1, CHANNELS=4, pattern 0, checksum off.
  - Sync lane: 2AA,035,035,12A,3A6,3A6,0AA,035,035,3AA, then 8×3A6.
  - Line-0 data: x0 lanes 0,1,2,3; x3 lanes 12..15.
  - out_frame_start pulses once per FS.
- Enable drop: drop enable on line 0, x=1. The frame completes, including FE and the 6-cycle VBLANK, then out_busy=0 and there is no further FS.
- cke stall: cke=0 for 5 cycles at an LS word. Outputs hold 0AA for the stall, then resume with 035 and the unchanged pixel sequence.
- Pattern latch: change pattern_sel 0→3 mid-frame. Current frame data stays ramp; the next frame shows checker (x0 y0 = 000, x1 y0 = 3FF).
- Checksum (macro on, same shape as the frame-shape test): CRC word after 12A with lane 0 = 0+4+8+12 = 24, lane 3 = 3+7+11+15 = 36. Line period = 7; the next LS arrives 7 cycles after the previous LS.
